// File: rtl/inbuf_pkg.sv
// rtl/inbuf_pkg.sv - shared bank state type and default sizes for the ping-pong input buffer
package inbuf_pkg;

    typedef enum logic [1:0] {
        BANK_EMPTY   = 2'd0,
        BANK_FILLING = 2'd1,
        BANK_FULL    = 2'd2
    } bank_state_e;

    localparam int unsigned INBUF_DATA_WIDTH = 8;
    localparam int unsigned INBUF_CHANNELS   = 4;
    localparam int unsigned INBUF_DEPTH      = 64;

endpackage

// File: rtl/inbuf_bank.sv
// rtl/inbuf_bank.sv - one CHANNELS-wide bank, synchronous write, registered read, no reset (SRAM)
module inbuf_bank
    import inbuf_pkg::*;
#(
    parameter int unsigned WORD_W = INBUF_CHANNELS * INBUF_DATA_WIDTH,
    parameter int unsigned DEPTH  = INBUF_DEPTH,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [WORD_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [WORD_W-1:0] rdata_o
);

    logic [WORD_W-1:0] mem_q [DEPTH];

    // store one beat per accepted write
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // read port register only moves on a real access, so the output holds otherwise
    always_ff @(posedge clk_i) begin
        if (re_i) begin
            rdata_o <= mem_q[raddr_i];
        end
    end

endmodule

// File: rtl/pingpong_input_buffer.sv
// rtl/pingpong_input_buffer.sv - double-banked input buffer; INBUF_ZERO_PAD_EN enables zero-padding reads
module pingpong_input_buffer
    import inbuf_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = INBUF_DATA_WIDTH,
    parameter int unsigned CHANNELS   = INBUF_CHANNELS,
    parameter int unsigned DEPTH      = INBUF_DEPTH,
    localparam int unsigned ADDR_W    = $clog2(DEPTH)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           wr_valid,
    output logic                           wr_ready,
    input  logic [CHANNELS*DATA_WIDTH-1:0] wr_data,
    input  logic                           wr_last,
    output logic                           rd_bank_valid,
    output logic [ADDR_W:0]                rd_count,
    input  logic                           rd_en,
    input  logic [ADDR_W-1:0]              rd_addr,
    input  logic                           rd_pad,
    output logic [CHANNELS*DATA_WIDTH-1:0] rd_data,
    output logic                           rd_data_valid,
    input  logic                           rd_release,
    output logic                           err_release
);

    localparam int unsigned CNT_W  = ADDR_W + 1;
    localparam int unsigned WORD_W = CHANNELS * DATA_WIDTH;

    bank_state_e       state_q [2];
    bank_state_e       state_d [2];
    logic [CNT_W-1:0]  count_q [2];
    logic [CNT_W-1:0]  count_d [2];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic              wr_bank_q, wr_bank_d;
    logic              rd_bank_q, rd_bank_d;
    logic              err_q, err_d;
    logic              init_q;
    logic              rd_valid_q, rd_sel_q, rd_zero_q;
    logic              wr_accept, wr_done, rd_accept, rel_accept;
    logic              rd_oor, pad_zero, rd_zero_d;
    logic [WORD_W-1:0] bank_rdata [2];

    // init_q keeps wr_ready low until the first edge after reset release
    assign wr_ready      = init_q & (state_q[wr_bank_q] != BANK_FULL);
    assign wr_accept     = wr_valid & wr_ready;
    assign wr_done       = wr_accept & (wr_last | (wr_ptr_q == ADDR_W'(DEPTH - 1)));
    assign rd_bank_valid = (state_q[rd_bank_q] == BANK_FULL);
    assign rd_count      = rd_bank_valid ? count_q[rd_bank_q] : '0;
    assign rd_accept     = rd_en & rd_bank_valid;
    assign rel_accept    = rd_release & rd_bank_valid;
    assign rd_oor        = ({1'b0, rd_addr} >= rd_count);

`ifdef INBUF_ZERO_PAD_EN
    assign pad_zero = rd_pad;
`else
    // padding disabled: rd_pad is tied off and folds away
    assign pad_zero = rd_pad & 1'b0;
`endif

    assign rd_zero_d = rd_oor | pad_zero;

    // bank state machines, write pointer and bank pointers
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        wr_ptr_d  = wr_ptr_q;
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        err_d     = err_q | (rd_release & ~rd_bank_valid);
        if (wr_accept) begin
            if (wr_done) begin
                state_d[wr_bank_q] = BANK_FULL;
                count_d[wr_bank_q] = {1'b0, wr_ptr_q} + CNT_W'(1);
                wr_ptr_d           = '0;
                wr_bank_d          = ~wr_bank_q;
            end else begin
                state_d[wr_bank_q] = BANK_FILLING;
                wr_ptr_d           = wr_ptr_q + ADDR_W'(1);
            end
        end
        // the released bank is always FULL, so it never collides with the write bank
        if (rel_accept) begin
            state_d[rd_bank_q] = BANK_EMPTY;
            rd_bank_d          = ~rd_bank_q;
        end
    end

    // control state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q[0] <= BANK_EMPTY;
            state_q[1] <= BANK_EMPTY;
            count_q[0] <= '0;
            count_q[1] <= '0;
            wr_ptr_q   <= '0;
            wr_bank_q  <= 1'b0;
            rd_bank_q  <= 1'b0;
            err_q      <= 1'b0;
            init_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            wr_ptr_q  <= wr_ptr_d;
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            err_q     <= err_d;
            init_q    <= 1'b1;
        end
    end

    // read response tracking; rd_zero_q starts set so rd_data reads 0 out of reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid_q <= 1'b0;
            rd_sel_q   <= 1'b0;
            rd_zero_q  <= 1'b1;
        end else begin
            rd_valid_q <= rd_accept;
            if (rd_accept) begin
                rd_sel_q  <= rd_bank_q;
                rd_zero_q <= rd_zero_d;
            end
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        inbuf_bank #(
            .WORD_W (WORD_W),
            .DEPTH  (DEPTH),
            .ADDR_W (ADDR_W)
        ) u_bank (
            .clk_i   (clk),
            .we_i    (wr_accept & (wr_bank_q == 1'(b))),
            .waddr_i (wr_ptr_q),
            .wdata_i (wr_data),
            .re_i    (rd_accept & ~rd_zero_d & (rd_bank_q == 1'(b))),
            .raddr_i (rd_addr),
            .rdata_o (bank_rdata[b])
        );
    end

    assign rd_data       = rd_zero_q ? '0 : bank_rdata[rd_sel_q];
    assign rd_data_valid = rd_valid_q;
    assign err_release   = err_q;

endmodule

// File: tb/tb_pingpong_input_buffer.sv
// tb/tb_pingpong_input_buffer.sv - self-checking bench for pingpong_input_buffer
module tb_pingpong_input_buffer;

    localparam int DW    = 8;
    localparam int CH    = 4;
    localparam int DEPTH = 64;
    localparam int AW    = $clog2(DEPTH);
    localparam int WW    = CH * DW;
`ifdef INBUF_ZERO_PAD_EN
    localparam bit PAD_EN = 1'b1;
`else
    localparam bit PAD_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          wr_valid, wr_ready, wr_last;
    logic [WW-1:0] wr_data;
    logic          rd_bank_valid;
    logic [AW:0]   rd_count;
    logic          rd_en, rd_pad, rd_release;
    logic [AW-1:0] rd_addr;
    logic [WW-1:0] rd_data;
    logic          rd_data_valid, err_release;

    always #5 clk = ~clk;

    pingpong_input_buffer #(.DATA_WIDTH(DW), .CHANNELS(CH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data), .wr_last(wr_last),
        .rd_bank_valid(rd_bank_valid), .rd_count(rd_count),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_pad(rd_pad),
        .rd_data(rd_data), .rd_data_valid(rd_data_valid),
        .rd_release(rd_release), .err_release(err_release)
    );

    // reference model: a queue of completed tiles plus the tile being written
    typedef struct {
        logic [WW-1:0] d [DEPTH];
        int            cnt;
    } tile_t;
    tile_t         tiles[$];
    logic [WW-1:0] part[$];
    bit            m_init;
    logic [WW-1:0] m_data;
    bit            m_dv, m_err;

    int n_vec = 0;
    int n_bad = 0;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    function automatic logic [WW-1:0] word(logic [7:0] base, int addr);
        logic [WW-1:0] w;
        for (int c = 0; c < CH; c++) w[c*DW +: DW] = base + 8'(addr) + 8'(c);
        return w;
    endfunction

    function automatic void model_reset();
        tiles.delete();
        part.delete();
        m_init = 0;
        m_data = '0;
        m_dv   = 0;
        m_err  = 0;
    endfunction

    function automatic void model_step();
        bit ready = m_init && (tiles.size() < 2);
        bit valid = (tiles.size() > 0);
        m_dv = 0;
        if (rd_en && valid) begin
            m_dv = 1;
            if (PAD_EN && rd_pad) m_data = '0;
            else if (int'(rd_addr) < tiles[0].cnt) m_data = tiles[0].d[rd_addr];
            else m_data = '0;
        end
        if (rd_release) begin
            if (valid) void'(tiles.pop_front());
            else m_err = 1;
        end
        if (wr_valid && ready) begin
            part.push_back(wr_data);
            if (wr_last || part.size() == DEPTH) begin
                tile_t t;
                t.cnt = part.size();
                for (int i = 0; i < part.size(); i++) t.d[i] = part[i];
                tiles.push_back(t);
                part.delete();
            end
        end
        m_init = 1;
    endfunction

    task automatic check_model(string tag);
        chk({tag, ":wr_ready"}, 32'(wr_ready), 32'(m_init && tiles.size() < 2));
        chk({tag, ":rd_bank_valid"}, 32'(rd_bank_valid), 32'(tiles.size() > 0));
        chk({tag, ":rd_count"}, 32'(rd_count), (tiles.size() > 0) ? 32'(tiles[0].cnt) : 32'd0);
        chk({tag, ":rd_data"}, rd_data, m_data);
        chk({tag, ":rd_data_valid"}, 32'(rd_data_valid), 32'(m_dv));
        chk({tag, ":err_release"}, 32'(err_release), 32'(m_err));
    endtask

    task automatic set_idle();
        wr_valid = 0; wr_last = 0; wr_data = '0;
        rd_en = 0; rd_addr = '0; rd_pad = 0; rd_release = 0;
    endtask

    task automatic cycle(string tag);
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_model(tag);
    endtask

    task automatic apply_reset();
        set_idle();
        rst_n = 0;
        #1;
        model_reset();
        check_model("rst");
        chk("rst_wr_ready", 32'(wr_ready), 32'd0);
        chk("rst_rd_bank_valid", 32'(rd_bank_valid), 32'd0);
        chk("rst_rd_count", 32'(rd_count), 32'd0);
        chk("rst_rd_data", rd_data, 32'd0);
        chk("rst_rd_data_valid", 32'(rd_data_valid), 32'd0);
        chk("rst_err", 32'(err_release), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;
        cycle("post_rst");
        chk("ready_after_rst", 32'(wr_ready), 32'd1);
        chk("no_stale_tile", 32'(rd_bank_valid), 32'd0);
    endtask

    task automatic wr_beat(logic [WW-1:0] d, bit last);
        wr_valid = 1; wr_data = d; wr_last = last;
        cycle("wr");
        set_idle();
    endtask

    task automatic rd_req(logic [AW-1:0] a, bit pad);
        rd_en = 1; rd_addr = a; rd_pad = pad;
        cycle("rd");
        set_idle();
    endtask

    typedef struct {
        bit            wv, wl, re, rp, rr;
        logic [WW-1:0] wd;
        logic [AW-1:0] ra;
        bit            e_ready, e_valid, e_dv, e_err;
        int            e_count;
        logic [WW-1:0] e_data;
    } vec_t;
    vec_t tbl[20];

    function automatic vec_t row(bit wv, bit wl, logic [WW-1:0] wd, bit re, logic [AW-1:0] ra,
                                 bit rp, bit rr, bit e_valid, int e_count,
                                 logic [WW-1:0] e_data, bit e_dv, bit e_err);
        vec_t v;
        v.wv = wv; v.wl = wl; v.wd = wd; v.re = re; v.ra = ra; v.rp = rp; v.rr = rr;
        v.e_ready = 1; v.e_valid = e_valid; v.e_count = e_count;
        v.e_data = e_data; v.e_dv = e_dv; v.e_err = e_err;
        return v;
    endfunction

    initial begin
        set_idle();
        // short tile of 10 beats, out-of-range read, release racing a single-beat tile, error release
        for (int i = 0; i < 10; i++)
            tbl[i] = row(1, i == 9, word(8'h10, i), 0, '0, 0, 0, i == 9, (i == 9) ? 10 : 0, '0, 0, 0);
        tbl[10] = row(0, 0, '0, 1, 6'd9, 0, 0, 1, 10, 32'h1c1b1a19, 1, 0);
        tbl[11] = row(0, 0, '0, 1, 6'd12, 0, 0, 1, 10, 32'h00000000, 1, 0);
        tbl[12] = row(0, 0, '0, 0, '0, 0, 0, 1, 10, 32'h00000000, 0, 0);
        tbl[13] = row(1, 1, 32'h23222120, 0, '0, 0, 1, 1, 1, 32'h00000000, 0, 0);
        tbl[14] = row(0, 0, '0, 1, 6'd0, 1, 0, 1, 1, PAD_EN ? 32'h0 : 32'h23222120, 1, 0);
        tbl[15] = row(0, 0, '0, 1, 6'd0, 0, 0, 1, 1, 32'h23222120, 1, 0);
        tbl[16] = row(0, 0, '0, 0, '0, 0, 1, 0, 0, 32'h23222120, 0, 0);
        tbl[17] = row(0, 0, '0, 0, '0, 0, 1, 0, 0, 32'h23222120, 0, 1);
        tbl[18] = row(1, 0, 32'h55aa55aa, 0, '0, 0, 0, 0, 0, 32'h23222120, 0, 1);
        tbl[19] = row(0, 0, '0, 0, '0, 0, 0, 0, 0, 32'h23222120, 0, 1);

        @(negedge clk);
        apply_reset();

        // full tile, lane c = addr + c
        for (int i = 0; i < DEPTH; i++) wr_beat(word(8'h00, i), 0);
        chk("full_valid", 32'(rd_bank_valid), 32'd1);
        chk("full_count", 32'(rd_count), 32'd64);
        rd_req(6'd5, 0);
        chk("full_rd5", rd_data, 32'h08070605);
        chk("full_rd5_dv", 32'(rd_data_valid), 32'd1);
        rd_req(6'd3, 1);
        chk("pad_rd3", rd_data, PAD_EN ? 32'h0 : 32'h06050403);
        chk("pad_rd3_dv", 32'(rd_data_valid), 32'd1);

        // second tile fills the other bank, then backpressure
        for (int i = 0; i < DEPTH; i++) wr_beat(word(8'h40, i), 0);
        chk("pp_stall", 32'(wr_ready), 32'd0);
        rd_release = 1;
        cycle("rel");
        set_idle();
        chk("pp_ready_after_rel", 32'(wr_ready), 32'd1);
        chk("pp_valid_after_rel", 32'(rd_bank_valid), 32'd1);
        rd_req(6'd0, 0);
        chk("pp_second_tile", rd_data, 32'h43424140);

        // reset mid-operation with a read pending and a partial tile
        for (int i = 0; i < 20; i++) wr_beat(word(8'h80, i), 0);
        rd_en = 1; rd_addr = 6'd1; rst_n = 0;
        #1;
        model_reset();
        chk("midrst_dv", 32'(rd_data_valid), 32'd0);
        chk("midrst_data", rd_data, 32'd0);
        @(posedge clk);
        #1;
        chk("midrst_dv_hold", 32'(rd_data_valid), 32'd0);
        chk("midrst_ready", 32'(wr_ready), 32'd0);
        @(negedge clk);
        apply_reset();

        // table-driven vectors
        foreach (tbl[i]) begin
            wr_valid = tbl[i].wv; wr_last = tbl[i].wl; wr_data = tbl[i].wd;
            rd_en = tbl[i].re; rd_addr = tbl[i].ra; rd_pad = tbl[i].rp; rd_release = tbl[i].rr;
            cycle($sformatf("tbl%0d_model", i));
            chk($sformatf("tbl%0d_ready", i), 32'(wr_ready), 32'(tbl[i].e_ready));
            chk($sformatf("tbl%0d_valid", i), 32'(rd_bank_valid), 32'(tbl[i].e_valid));
            chk($sformatf("tbl%0d_count", i), 32'(rd_count), 32'(tbl[i].e_count));
            chk($sformatf("tbl%0d_data", i), rd_data, tbl[i].e_data);
            chk($sformatf("tbl%0d_dv", i), 32'(rd_data_valid), 32'(tbl[i].e_dv));
            chk($sformatf("tbl%0d_err", i), 32'(err_release), 32'(tbl[i].e_err));
            set_idle();
        end

        // randomized traffic against the model
        apply_reset();
        for (int n = 0; n < 3000; n++) begin
            wr_valid   = ($urandom_range(0, 9) < 7);
            wr_last    = ($urandom_range(0, 15) == 0);
            wr_data    = $urandom();
            rd_en      = ($urandom_range(0, 1) == 1);
            rd_addr    = AW'($urandom_range(0, DEPTH - 1));
            rd_pad     = ($urandom_range(0, 4) == 0);
            rd_release = ($urandom_range(0, 19) == 0);
            cycle($sformatf("rnd%0d", n));
        end
        set_idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
